// File: rtl/sevenseg_scan_controller_if.sv
// sevenseg_scan_controller_if: load/value in, scan outputs and pending status back
interface sevenseg_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    pending;
    logic [3:0]              scan_nibble;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    frame_done;

    modport master (
        output load, value,
        input  pending, scan_nibble, digit_en, frame_done
    );

    modport slave (
        input  load, value,
        output pending, scan_nibble, digit_en, frame_done
    );
endinterface

// File: rtl/sevenseg_scan_controller.sv
// sevenseg_scan_controller: double-buffered seven-segment digit scanner; LEADING_ZERO_BLANK_EN darkens leading zero digits
module sevenseg_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input logic                       clock,
    input logic                       reset_n,
    sevenseg_scan_controller_if.slave bus
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(PRESCALE + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] DRIVE_END = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(1);

    typedef enum logic {GUARD, DRIVE} state_t;

    state_t                state, state_nx;
    logic [IW-1:0]         idx, idx_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [W-1:0]          active, shadow, active_nx;
    logic [3:0]            nibble;
    logic                  pending, lit, slot_end, frame_done, swap;
    logic [NUM_DIGITS-1:0] digit_en;

`ifdef LEADING_ZERO_BLANK_EN
    assign lit = (idx == '0) || ((active >> (4 * idx)) != '0);
`else
    assign lit = 1'b1;
`endif

    // Slot sequencing: 2-cycle dark guard (covers decoder latency), then PRESCALE lit cycles
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt + 1'b1;
        slot_end = 1'b0;
        digit_en = '0;
        if (state == GUARD) begin
            if (cnt == GUARD_END) begin
                state_nx = DRIVE;
                cnt_nx   = '0;
            end
        end else begin
            digit_en = lit ? ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx) : '0;
            if (cnt == DRIVE_END) begin
                slot_end = 1'b1;
                state_nx = GUARD;
                cnt_nx   = '0;
                idx_nx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    assign frame_done = slot_end && (idx == LAST_IDX);
    assign swap       = frame_done && pending;
    assign active_nx  = swap ? shadow : active;

    // Scan state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= GUARD;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    // Display buffers: shadow takes loads, active swaps only at frame end; nibble refreshed on guard entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            nibble  <= '0;
        end else begin
            active  <= active_nx;
            pending <= bus.load | (pending & ~swap);
            if (bus.load)
                shadow <= bus.value;
            if (slot_end)
                nibble <= active_nx[4*idx_nx +: 4];
        end
    end

    assign bus.pending     = pending;
    assign bus.scan_nibble = nibble;
    assign bus.digit_en    = digit_en;
    assign bus.frame_done  = frame_done;
endmodule

// File: tb/tb_sevenseg_scan_controller.sv
// tb_sevenseg_scan_controller: stimulus queues expected frame contents; monitor checks each frame at frame_done
module tb_sevenseg_scan_controller;
    localparam int ND    = 4;
    localparam int PS    = 4;
    localparam int FRAME = ND * (PS + 2);

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    logic [15:0] exp_q[$];

    sevenseg_scan_controller_if #(.NUM_DIGITS(ND)) bus();

    sevenseg_scan_controller #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Cycle index since reset release
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [3:0] lit_mask(input logic [15:0] v);
        logic [3:0] m;
        m = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < ND; i++) m[i] = ((v >> (4 * i)) != 16'h0);
`endif
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic at(input int c);
        do @(negedge clock); while (cyc < c);
    endtask

    task automatic do_load(input int c, input logic [15:0] v);
        at(c);
        bus.load  = 1'b1;
        bus.value = v;
        at(c + 1);
        bus.load  = 1'b0;
        bus.value = 16'hDEAD;
    endtask

    // Monitor: accumulate what each frame displayed and compare at frame_done
    initial begin
        logic [15:0] acc_val, e;
        logic [3:0]  acc_mask;
        int          acc_lit, acc_len;
        bit          acc_bad;
        acc_val = '0; acc_mask = '0; acc_lit = 0; acc_len = 0; acc_bad = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                acc_val = '0; acc_mask = '0; acc_lit = 0; acc_len = 0; acc_bad = 0;
            end else begin
                acc_len++;
                if (!$onehot0(bus.digit_en)) acc_bad = 1;
                for (int i = 0; i < ND; i++) begin
                    if (bus.digit_en[i]) begin
                        if (acc_mask[i] && acc_val[4*i +: 4] != bus.scan_nibble) acc_bad = 1;
                        acc_val[4*i +: 4] = bus.scan_nibble;
                        acc_mask[i] = 1'b1;
                        acc_lit++;
                    end
                end
                if (bus.frame_done) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame: unexpected frame_done, shown %h", acc_val);
                    end else begin
                        e = exp_q.pop_front();
                        if (acc_val !== e || acc_mask !== lit_mask(e) || acc_lit != $countones(lit_mask(e)) * PS
                            || acc_len != FRAME || acc_bad) begin
                            errors++;
                            $display("FAIL frame: shown %h mask %b lit %0d len %0d glitch %0b, expected %h mask %b lit %0d len %0d",
                                     acc_val, acc_mask, acc_lit, acc_len, acc_bad,
                                     e, lit_mask(e), $countones(lit_mask(e)) * PS, FRAME);
                        end
                    end
                    acc_val = '0; acc_mask = '0; acc_lit = 0; acc_len = 0; acc_bad = 0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        bus.load  = 1'b0;
        bus.value = 16'hDEAD;
        repeat (3) @(negedge clock);
        check("rst_digit_en", bus.digit_en, 0);
        check("rst_scan_nibble", bus.scan_nibble, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_pending", bus.pending, 0);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        @(posedge clock);
        #1 reset_n = 1'b1;
        at(0);  check("guard_c0", bus.digit_en, 0);
        at(1);  check("guard_c1", bus.digit_en, 0);
        at(2);  check("first_drive", bus.digit_en, 4'b0001);
        at(5);  check("drive0_end", bus.digit_en, 4'b0001);
        at(6);  check("gap", bus.digit_en, 0);
        at(8);  check("drive1", bus.digit_en, 4'b0010);
        at(22); check("frame_done_early", bus.frame_done, 0);
        at(23); check("frame_done_c23", bus.frame_done, 1);
        // load mid-frame 1, shown from frame 2
        do_load(34, 16'h1234);
        exp_q.push_back(16'h1234);
        check("pending_after_load", bus.pending, 1);
        at(47); check("pending_held", bus.pending, 1);
        at(48); check("pending_cleared", bus.pending, 0);
        check("new_digit0_guard", bus.scan_nibble, 4'h4);
        // shadow AAAA pending, 5555 loaded in the swap cycle
        do_load(53, 16'hAAAA);
        exp_q.push_back(16'hAAAA);
        at(71); check("swap_cycle", bus.frame_done, 1);
        bus.load  = 1'b1;
        bus.value = 16'h5555;
        at(72);
        bus.load  = 1'b0;
        bus.value = 16'hDEAD;
        exp_q.push_back(16'h5555);
        check("pending_kept", bus.pending, 1);
        check("swap_old_shadow", bus.scan_nibble, 4'hA);
        at(96); check("pending_after_2nd_swap", bus.pending, 0);
        check("nibble_5", bus.scan_nibble, 4'h5);
        // back-to-back loads: last wins
        at(100);
        bus.load  = 1'b1;
        bus.value = 16'h0001;
        at(101);
        bus.value = 16'h0002;
        at(102);
        bus.load  = 1'b0;
        bus.value = 16'hDEAD;
        exp_q.push_back(16'h0002);
        do_load(125, 16'h0070);
        exp_q.push_back(16'h0070);
        // frame 7 shows 8888, interrupted by reset during digit 2 DRIVE
        do_load(150, 16'h8888);
        at(170); check("frame7_digit0", bus.scan_nibble, 4'h8);
        do_load(172, 16'h1111);
        at(183); check("pre_reset_drive2", bus.digit_en, 4'b0100);
        check("pre_reset_pending", bus.pending, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_blank", bus.digit_en, 0);
        check("async_pending", bus.pending, 0);
        check("async_nibble", bus.scan_nibble, 0);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        at(0);  check("restart_guard", bus.digit_en, 0);
        at(2);  check("restart_digit0", bus.digit_en, 4'b0001);
        check("restart_nibble", bus.scan_nibble, 0);
        at(30); check("discarded_pending", bus.pending, 0);
        at(50); check("all_frames_seen", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/sevenseg_scan_controller.md
# sevenseg_scan_controller

Time-multiplexing scan controller for the vending machine's multi-digit seven-segment display. It holds a packed BCD/hex display value, feeds one nibble at a time to the shared registered seven-segment decoder (`sevensegmentdisplay`), and drives the one-hot digit enables in step with the decoder's one-cycle output latency. New values are double-buffered and swapped only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits; minimum 2.
- `PRESCALE`, 50000: clock cycles each digit is driven (DRIVE length); minimum 1.
- `clock` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: reset; asynchronous, active-low.
- `load` in 1: single-cycle strobe; captures `value` into the shadow register.
- `value` in 4*NUM_DIGITS: packed nibbles; `value[3:0]` is digit 0, the least significant digit.
- `pending` out 1: shadow holds a value not yet shown.
- `scan_nibble` out 4: nibble to the shared decoder's `printnumber` input.
- `digit_en` out NUM_DIGITS: one-hot, active-high digit enable; all zero when no digit is lit.
- `frame_done` out 1: one-cycle pulse on the last DRIVE cycle of digit NUM_DIGITS-1.

## Operation
- Registers:
  - `active` and `shadow` are 4*NUM_DIGITS bits wide.
  - `idx` ranges over 0..NUM_DIGITS-1.
  - `cnt` is a prescale counter, $clog2(PRESCALE+1) bits wide.
  - `state` is one of {GUARD, DRIVE}.
- GUARD:
  - Lasts exactly 2 cycles.
  - `digit_en`=0.
  - `scan_nibble` = `active[4*idx+:4]`, set on entry.
  - The guard covers the decoder's registered latency and prevents ghosting.
  - Transitions to DRIVE with `cnt`=0.
- DRIVE:
  - `digit_en` = one-hot(`idx`); `cnt` increments each cycle.
  - On `cnt`==PRESCALE-1: `idx` wraps modulo NUM_DIGITS and the block returns to GUARD.
- Slot length is PRESCALE+2 cycles; frame length is NUM_DIGITS*(PRESCALE+2) cycles.
- Load:
  - On `load`=1: `shadow` <= `value` and `pending` <= 1.
  - A second load while `pending` overwrites `shadow`; the last value wins.
- Swap:
  - Occurs in the `frame_done` cycle when `pending`=1.
  - Effect: `active` <= `shadow` and `pending` <= 0.
  - The new value first appears in digit 0's GUARD on the next cycle.
- Simultaneous `load` and swap:
  - The swap uses the pre-edge `shadow`.
  - `shadow` takes the new `value`.
  - `pending` stays 1, so the new value is shown at the following frame.
- `value` is sampled only on `load`; it is ignored otherwise.
- No arithmetic beyond the counters; all nibble codes 0–F pass through unchanged.

## Timing
- Reset values (asynchronous on `reset_n`=0):
  - Outputs: `digit_en`=0, `scan_nibble`=0, `frame_done`=0, `pending`=0.
  - Internal: `active`=0, `shadow`=0, `idx`=0, `cnt`=0, `state`=GUARD.
- After `reset_n` rises, the first digit_en[0] assertion is on the 3rd rising edge.
- Reset mid-frame blanks all digits immediately and discards any pending value.
- `scan_nibble` changes only on GUARD entry; it is stable throughout DRIVE.
- `load`→display latency: variable, bounded by one frame plus 2 cycles after the next `frame_done`.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - During DRIVE of digit i (i≥1), `digit_en` is held 0 if `active` nibbles i..NUM_DIGITS-1 are all zero.
  - Slot timing, `idx` sequencing and `frame_done` are unchanged.
  - Digit 0 is always lit.
- `LEADING_ZERO_BLANK_EN` undefined: every digit is lit in its DRIVE slot regardless of value.

## Test plan
Bench parameters: NUM_DIGITS=4, PRESCALE=4, giving a 6-cycle slot and a 24-cycle frame.
- **Reset/scan order:**
  - Stimulus: release reset, no load.
  - Required response: `digit_en`=0 for 2 cycles, then 0001 for 4 cycles, gap, 0010, 0100, 1000; `scan_nibble`=0 throughout.
  - `frame_done` pulses at cycle 23.
- **Load and swap:**
  - Stimulus: `load` with `value`=16'h1234 mid-frame.
  - Required response: `pending`=1 until `frame_done`; next frame `scan_nibble` reads 4,3,2,1 for digits 0–3.
  - No digit of the current frame changes.
- **Load coincident with frame_done:**
  - Stimulus: shadow=16'hAAAA pending; `load` 16'h5555 in the `frame_done` cycle.
  - Required response: next frame shows A,A,A,A; `pending` stays 1; the frame after shows 5,5,5,5.
- **Back-to-back loads:**
  - Stimulus: loads of 16'h0001 then 16'h0002 within one frame.
  - Required response: only 0002 is displayed.
- **Leading-zero blank:**
  - Stimulus: `value` 16'h0070.
  - With macro: digit_en shows 0001 and 0010 only; slots 2–3 dark but still 6 cycles each.
  - Without macro: all four digits are lit.
- **Reset mid-DRIVE:**
  - Stimulus: `reset_n` low during digit 2 DRIVE.
  - Required response: `digit_en`=0 in the same cycle, with no clock edge needed; `pending`=0; scanning restarts at digit 0.
